canden_multi: RTL

CANDEN_MULTI -- requirements
Module: canden_multi

---
 rtl/canden_pkg.sv | 14 +
 rtl/canden_chan.sv | 110 +++++++++++
 rtl/canden_multi.sv | 46 ++++
 3 files changed

// File: rtl/canden_pkg.sv
// Shared types and default sizes for the multi-channel clock gate.
package canden_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } chan_state_t;

    localparam int NCH_DEFAULT   = 4;
    localparam int DIVW_DEFAULT  = 8;
    localparam int HOLDW_DEFAULT = 4;

endpackage

// File: rtl/canden_chan.sv
// One gated-clock channel: request FSM with hold-off, clock divider,
// negative-level enable latch and the output AND gate.
module canden_chan
    import canden_pkg::*;
#(
    parameter int DIVW  = DIVW_DEFAULT,
    parameter int HOLDW = HOLDW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             test_en,
    input  logic [DIVW-1:0]  div_ratio,
    input  logic [HOLDW-1:0] hold_cycles,
    output logic             iz,
    output logic             ce,
    output logic             active
);

    chan_state_t      state_reg, state_next;
    logic [HOLDW-1:0] hcnt_reg, hcnt_next;
    logic [DIVW-1:0]  dcnt_reg, dcnt_next;
    logic             ce_reg, ce_next;
    logic             div_step;
    logic [DIVW-1:0]  reload_val;
    logic             en_latch;

    // Ratios 0 and 1 both collapse to "every cycle".
    assign reload_val = (div_ratio >= DIVW'(2)) ? (div_ratio - DIVW'(1)) : '0;

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        dcnt_next  = dcnt_reg;
        ce_next    = 1'b0;
        div_step   = 1'b0;
        case (state_reg)
            ST_OFF: begin
                if (req) begin
                    state_next = ST_ON;
                    ce_next    = 1'b1;
                    dcnt_next  = reload_val;
                end
            end
            ST_ON: begin
                if (!req) begin
                    if (hold_cycles == '0) begin
                        state_next = ST_OFF;
                    end else begin
                        state_next = ST_HOLD;
                        hcnt_next  = hold_cycles - HOLDW'(1);
                        div_step   = 1'b1;
                    end
                end else begin
                    div_step = 1'b1;
                end
            end
            ST_HOLD: begin
                if (req) begin
                    state_next = ST_ON;
                    div_step   = 1'b1;
                end else if (hcnt_reg == '0) begin
                    state_next = ST_OFF;
                end else begin
                    hcnt_next = hcnt_reg - HOLDW'(1);
                    div_step  = 1'b1;
                end
            end
            default: state_next = ST_OFF;
        endcase

        // New ratio is only picked up on reload, so a count in flight is never cut short.
        if (div_step) begin
            if (dcnt_reg == '0) begin
                ce_next   = 1'b1;
                dcnt_next = reload_val;
            end else begin
                dcnt_next = dcnt_reg - DIVW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_OFF;
            hcnt_reg  <= '0;
            dcnt_reg  <= '0;
            ce_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            dcnt_reg  <= dcnt_next;
            ce_reg    <= ce_next;
        end
    end

    // Transparent while clk is low, so the AND below never sees a mid-high change.
    always_latch begin
        if (!rst_n) begin
            en_latch <= 1'b0;
        end else if (!clk) begin
            en_latch <= ce_reg | test_en;
        end
    end

    assign iz     = clk & en_latch;
    assign ce     = ce_reg;
    assign active = (state_reg != ST_OFF);

endmodule

// File: rtl/canden_multi.sv
// Bank of NCH independent gated clocks sharing one input clock and hold-off count.
module canden_multi
    import canden_pkg::*;
#(
    parameter int NCH   = NCH_DEFAULT,
    parameter int DIVW  = DIVW_DEFAULT,
    parameter int HOLDW = HOLDW_DEFAULT
) (
    input  logic                CLKIN,
    input  logic                RSTN,
    input  logic [NCH-1:0]      SEN,
    input  logic [NCH-1:0]      DEN,
    input  logic [NCH-1:0]      DYNEN,
    input  logic [NCH*DIVW-1:0] DIV,
    input  logic [HOLDW-1:0]    HOLD,
    input  logic                TEST_EN,
    output logic [NCH-1:0]      IZ,
    output logic [NCH-1:0]      CE,
    output logic [NCH-1:0]      ACTIVE
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic chan_req;

            assign chan_req = DEN[gi] ? DYNEN[gi] : SEN[gi];

            canden_chan #(
                .DIVW  (DIVW),
                .HOLDW (HOLDW)
            ) u_chan (
                .clk         (CLKIN),
                .rst_n       (RSTN),
                .req         (chan_req),
                .test_en     (TEST_EN),
                .div_ratio   (DIV[gi*DIVW +: DIVW]),
                .hold_cycles (HOLD),
                .iz          (IZ[gi]),
                .ce          (CE[gi]),
                .active      (ACTIVE[gi])
            );
        end
    endgenerate

endmodule
